// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = 7'b000_0000;
    localparam ctrl_t CTRL_RESET  = 7'b001_0100;
    localparam ctrl_t CTRL_BRANCH = 7'b111_1111;
    localparam ctrl_t CTRL_BUBBLE = 7'b000_1111;
    localparam ctrl_t CTRL_NORMAL = 7'b110_1011;

    // x0 is hardwired to zero, so it can never carry a real dependency
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        reg_match = (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and stage-control outputs between the pipeline and the stall sequencer.
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
        input  mem_error, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_req, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en,
        output mem_error, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_stall_ctrl_load_use.sv
// Detects a load in EX whose destination feeds either source of the instruction in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    output logic       load_use
);

    assign load_use = ex_mem_read & (reg_match(ex_rd, id_rs1) | reg_match(ex_rd, id_rs2));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer: merges load-use, taken-branch and data-memory wait conditions
// into per-stage enables, with a memory timeout and saturating performance counters.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_stall_ctrl_if.slave bus
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_r;
    state_t           state_next_s;
    logic [WC_W-1:0]  wait_cnt_r;
    logic [WC_W-1:0]  wait_cnt_next_s;
    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] flush_events_r;
    logic             mem_error_r;
    logic             load_use_s;
    logic             mem_miss_s;
    logic             advance_s;
    logic             stall_inc_s;
    logic             flush_inc_s;
    ctrl_t            dec_s;
    ctrl_t            ctrl_s;

    load_use_detect u_load_use (
        .ex_mem_read (bus.ex_mem_read),
        .ex_rd       (bus.ex_rd),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .load_use    (load_use_s)
    );

    assign mem_miss_s = bus.mem_req & ~bus.mem_ready;

    // Next-state, wait counter and stage-control decode
    always_comb begin
        state_next_s    = state_r;
        wait_cnt_next_s = wait_cnt_r;
        advance_s       = 1'b0;
        stall_inc_s     = 1'b0;
        flush_inc_s     = 1'b0;
        dec_s           = CTRL_FREEZE;
        case (state_r)
            RUN: begin
                if (mem_miss_s) begin
                    state_next_s    = MEM_WAIT;
                    wait_cnt_next_s = {WC_W{1'b0}};
                    stall_inc_s     = 1'b1;
                end else begin
                    advance_s = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_next_s = RUN;
                    advance_s    = 1'b1;
                end else begin
                    stall_inc_s     = 1'b1;
                    wait_cnt_next_s = wait_cnt_r + WC_W'(1);
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_next_s = ERROR;
                    end else begin
                        state_next_s = MEM_WAIT;
                    end
                end
            end
            ERROR: begin
                state_next_s = ERROR;
            end
            default: begin
                state_next_s    = RUN;
                wait_cnt_next_s = {WC_W{1'b0}};
            end
        endcase
        // A taken branch squashes the ID instruction, so its load-use hazard is moot
        if (advance_s && bus.ex_branch_taken) begin
            dec_s       = CTRL_BRANCH;
            flush_inc_s = 1'b1;
        end else if (advance_s && load_use_s) begin
            dec_s       = CTRL_BUBBLE;
            stall_inc_s = 1'b1;
        end else if (advance_s) begin
            dec_s = CTRL_NORMAL;
        end else begin
            dec_s = CTRL_FREEZE;
        end
    end

    // Reset overrides the decoded controls while it is held
    always_comb begin
        ctrl_s = dec_s;
        if (rst) begin
            ctrl_s = CTRL_RESET;
        end else begin
            ctrl_s = dec_s;
        end
    end

    // State, wait counter, sticky error and saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= RUN;
            wait_cnt_r     <= {WC_W{1'b0}};
            stall_cycles_r <= {CNT_W{1'b0}};
            flush_events_r <= {CNT_W{1'b0}};
            mem_error_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            wait_cnt_r  <= wait_cnt_next_s;
            mem_error_r <= mem_error_r | (state_next_s == ERROR);
            if (stall_inc_s && (stall_cycles_r != CNT_MAX)) begin
                stall_cycles_r <= stall_cycles_r + CNT_W'(1);
            end
            if (flush_inc_s && (flush_events_r != CNT_MAX)) begin
                flush_events_r <= flush_events_r + CNT_W'(1);
            end
        end
    end

    assign bus.pc_en        = ctrl_s.pc_en;
    assign bus.ifid_en      = ctrl_s.ifid_en;
    assign bus.ifid_flush   = ctrl_s.ifid_flush;
    assign bus.idex_en      = ctrl_s.idex_en;
    assign bus.idex_flush   = ctrl_s.idex_flush;
    assign bus.exmem_en     = ctrl_s.exmem_en;
    assign bus.memwb_en     = ctrl_s.memwb_en;
    assign bus.mem_error    = mem_error_r;
    assign bus.stall_cycles = stall_cycles_r;
    assign bus.flush_events = flush_events_r;

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It combines three conditions into one set of per-stage enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
- load-use hazard;
- taken branch resolved in EX;
- data-memory wait states (req/ready handshake).

It also enforces a memory timeout and keeps saturating performance counters.

Parameters:
MEM_TIMEOUT, 15, max MEM_WAIT cycles without mem_ready before ERROR (>=1)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
id_rs1  in  5  rs1 field (instr[19:15]) of instruction in IF/ID
id_rs2  in  5  rs2 field (instr[24:20]) of instruction in IF/ID
ex_rd  in  5  destination register of instruction in ID/EX
ex_mem_read  in  1  instruction in ID/EX is a load
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_req  in  1  MEM stage issues a data-memory access this cycle
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  clear IF/ID to NOP
idex_en  out  1  ID/EX register enable
idex_flush  out  1  load bubble (NOP) into ID/EX
exmem_en  out  1  EX/MEM register enable
memwb_en  out  1  MEM/WB register enable
mem_error  out  1  sticky memory-timeout flag (registered)
stall_cycles  out  CNT_W  cycles with pc_en=0 (excluding reset/ERROR)
flush_events  out  CNT_W  number of taken-branch flushes

Behaviour:
- Reset (rst=1 sampled at clk edge) does the following:
  - state=RUN, wait_cnt=0, counters=0, mem_error=0.
  - While rst is high, outputs are forced: all *_en=0, ifid_flush=idex_flush=1.
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: pipeline frozen waiting on mem_ready.
  - ERROR: terminal until reset.
- mem_miss = mem_req & ~mem_ready.
- load_use = ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2). x0 never causes a stall.
- Enables/flushes are combinational from state and inputs. Counters, state and mem_error are registered.
- RUN with mem_miss is a freeze cycle:
  - all *_en=0, flushes=0.
  - next state MEM_WAIT, wait_cnt<=0.
- MEM_WAIT with ~mem_ready is a freeze cycle:
  - all *_en=0, flushes=0.
  - wait_cnt increments.
  - if wait_cnt==MEM_TIMEOUT-1, next state ERROR.
- MEM_WAIT with mem_ready is an advance cycle; next state RUN. Inputs mem_req/ex_*/id_* are ignored during freeze; upstream holds them stable.
- An advance cycle is either RUN with ~mem_miss, or MEM_WAIT with mem_ready. Priority, in this order:
  1. ex_branch_taken: all *_en=1, ifid_flush=1, idex_flush=1; flush_events+1. Any load_use is ignored because the ID instruction is squashed.
  2. load_use: pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1. This is a one-cycle bubble; it re-evaluates next cycle.
  3. Otherwise: all *_en=1, flushes=0.
- ERROR:
  - all *_en=0, flushes=0, mem_error=1 (asserted the first cycle in ERROR, held until rst).
  - counters frozen.
- mem_ready without mem_req is ignored in RUN.
- mem_ready in the same cycle as mem_req in RUN means zero wait states (no freeze).
- stall_cycles increments on every cycle in RUN/MEM_WAIT with pc_en=0, covering both freeze and load-use cycles.
- Counters saturate at all-ones; no wrap.
- Reset mid-MEM_WAIT, or in ERROR, returns to RUN next cycle with wait_cnt cleared. Any in-flight access is abandoned.
- Timeout total: 1 RUN freeze cycle + MEM_TIMEOUT MEM_WAIT cycles. ERROR is entered on the following edge.

Decomposition:
- Package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT, ERROR} (2 bits)
  - REG_X0=5'd0
  - rs1/rs2 field bit-position constants
- Sub-module load_use_detect (combinational): ex_mem_read, ex_rd, id_rs1, id_rs2 -> load_use.
- Top holds the FSM, wait counter, the two saturating counters and output decode.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5 in RUN -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1 for one cycle; stall_cycles 0->1.
2. x0 case: ex_mem_read=1, ex_rd=0, id_rs2=0 -> all *_en=1, no flush, stall_cycles stays 0.
3. Branch plus load-use the same cycle: ex_branch_taken=1, ex_mem_read=1, ex_rd=7, id_rs1=7 -> pc_en=1, ifid_flush=idex_flush=1, flush_events=1, stall_cycles=0.
4. Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> all *_en=0 for 3 cycles (RUN, MEM_WAIT, MEM_WAIT), release cycle all *_en=1, state RUN; stall_cycles=3.
5. Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready never -> 5 freeze cycles, then ERROR with mem_error=1 held; assert rst one cycle -> mem_error=0, state RUN, counters 0.
6. Saturation with CNT_W=3: 10 consecutive load-use cycles -> stall_cycles stops at 7.
